idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pkg.sv | 117 +++++++++++
 rtl/idu_dec.sv | 208 ++++++++++++++++++++
 rtl/idu_pipe.sv | 148 ++++++++++++++
 tb/tb_idu_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared encodings for the instruction decode unit: opcodes, funct fields,
// operation codes and the decoded control bundle carried through the queue.
package idu_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [5:0] F6_SRL    = 6'b000000;
    localparam logic [5:0] F6_SRA    = 6'b010000;

    localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] SYS_MRET   = 32'h3020_0073;

    localparam int INST_TYPE_W = 4;
    localparam int ALU_OP_W    = 4;
    localparam int LSU_OP_W    = 4;
    localparam int BPU_OP_W    = 4;
    localparam int CSR_OP_W    = 3;
    localparam int MDU_OP_W    = 4;

    localparam logic [INST_TYPE_W-1:0] INST_NOP    = 4'd0;
    localparam logic [INST_TYPE_W-1:0] INST_ALU    = 4'd1;
    localparam logic [INST_TYPE_W-1:0] INST_LUI    = 4'd2;
    localparam logic [INST_TYPE_W-1:0] INST_AUIPC  = 4'd3;
    localparam logic [INST_TYPE_W-1:0] INST_LOAD   = 4'd4;
    localparam logic [INST_TYPE_W-1:0] INST_STORE  = 4'd5;
    localparam logic [INST_TYPE_W-1:0] INST_BRANCH = 4'd6;
    localparam logic [INST_TYPE_W-1:0] INST_JAL    = 4'd7;
    localparam logic [INST_TYPE_W-1:0] INST_JALR   = 4'd8;
    localparam logic [INST_TYPE_W-1:0] INST_CSR    = 4'd9;
    localparam logic [INST_TYPE_W-1:0] INST_MDU    = 4'd10;
    localparam logic [INST_TYPE_W-1:0] INST_SYS    = 4'd11;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LUI  = 4'd11;

    localparam logic [LSU_OP_W-1:0] LSU_OP_NOP = 4'd0;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LB  = 4'd1;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LH  = 4'd2;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LW  = 4'd3;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LBU = 4'd4;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LHU = 4'd5;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SB  = 4'd6;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SH  = 4'd7;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SW  = 4'd8;

    localparam logic [BPU_OP_W-1:0] BPU_OP_NOP  = 4'd0;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BEQ  = 4'd1;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BNE  = 4'd2;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BLT  = 4'd3;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BGE  = 4'd4;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BLTU = 4'd5;
    localparam logic [BPU_OP_W-1:0] BPU_OP_BGEU = 4'd6;
    localparam logic [BPU_OP_W-1:0] BPU_OP_JAL  = 4'd7;
    localparam logic [BPU_OP_W-1:0] BPU_OP_JALR = 4'd8;

    localparam logic [CSR_OP_W-1:0] CSR_OP_NOP   = 3'd0;
    localparam logic [CSR_OP_W-1:0] CSR_OP_RW    = 3'd1;
    localparam logic [CSR_OP_W-1:0] CSR_OP_RS    = 3'd2;
    localparam logic [CSR_OP_W-1:0] CSR_OP_ECALL = 3'd3;
    localparam logic [CSR_OP_W-1:0] CSR_OP_MRET  = 3'd4;

    localparam logic [MDU_OP_W-1:0] MDU_OP_NOP    = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MUL    = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULH   = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULHSU = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULHU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIV    = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU   = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_OP_REM    = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_OP_REMU   = 4'd8;

    typedef struct packed {
        logic [INST_TYPE_W-1:0] inst_type;
        logic [ALU_OP_W-1:0]    alu_op;
        logic [LSU_OP_W-1:0]    lsu_op;
        logic [BPU_OP_W-1:0]    bpu_op;
        logic [CSR_OP_W-1:0]    csr_op;
        logic [MDU_OP_W-1:0]    mdu_op;
        logic                   wsel;
        logic                   wena;
        logic                   rena1;
        logic                   rena2;
        logic [4:0]             waddr;
        logic [4:0]             raddr1;
        logic [4:0]             raddr2;
        logic                   illegal;
        logic                   ebreak;
    } dec_ctrl_t;

    localparam dec_ctrl_t DEC_CTRL_NOP = '0;

endpackage

// File: rtl/idu_dec.sv
// Pure combinational RV32I/RV64I-base + Zicsr + optional RV-M decoder.
// Illegal encodings collapse to an all-NOP bundle with only the illegal flag set.
module idu_dec
    import idu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic [31:0]     inst_i,
    output dec_ctrl_t       ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_st_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;
    logic [XLEN-1:0] shamt_s;
    logic [XLEN-1:0] csr_addr_s;
    logic            sll_ok_s;
    logic            sr_ok_s;
    logic            legal_s;
    dec_ctrl_t       raw_s;
    logic [XLEN-1:0] imm_raw_s;

    assign opcode_s   = inst_i[6:0];
    assign funct3_s   = inst_i[14:12];
    assign funct7_s   = inst_i[31:25];
    assign imm_i_s    = XLEN'($signed(inst_i[31:20]));
    assign imm_st_s   = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b_s    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u_s    = XLEN'($signed({inst_i[31:12], 12'h000}));
    assign imm_j_s    = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign csr_addr_s = XLEN'(inst_i[31:20]);

    // RV64 shifts borrow bit 25 for the shamt, so only funct6 is checked there.
    assign shamt_s  = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
    assign sll_ok_s = (XLEN == 64) ? (inst_i[31:26] == F6_SRL) : (funct7_s == F7_BASE);
    assign sr_ok_s  = (XLEN == 64) ? ((inst_i[31:26] == F6_SRL) || (inst_i[31:26] == F6_SRA))
                                   : ((funct7_s == F7_BASE) || (funct7_s == F7_ALT));

    // Raw field decode; legality is resolved alongside and applied afterwards.
    always_comb begin
        raw_s        = DEC_CTRL_NOP;
        raw_s.waddr  = inst_i[11:7];
        raw_s.raddr1 = inst_i[19:15];
        raw_s.raddr2 = inst_i[24:20];
        imm_raw_s    = '0;
        legal_s      = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                legal_s = 1'b1; raw_s.inst_type = INST_LUI; raw_s.alu_op = ALU_OP_LUI;
                raw_s.wena = 1'b1; imm_raw_s = imm_u_s;
            end
            OPC_AUIPC: begin
                legal_s = 1'b1; raw_s.inst_type = INST_AUIPC; raw_s.alu_op = ALU_OP_ADD;
                raw_s.wena = 1'b1; imm_raw_s = imm_u_s;
            end
            OPC_JAL: begin
                legal_s = 1'b1; raw_s.inst_type = INST_JAL; raw_s.bpu_op = BPU_OP_JAL;
                raw_s.wena = 1'b1; imm_raw_s = imm_j_s;
            end
            OPC_JALR: begin
                legal_s = (funct3_s == 3'b000); raw_s.inst_type = INST_JALR; raw_s.bpu_op = BPU_OP_JALR;
                raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; imm_raw_s = imm_i_s;
            end
            OPC_BRANCH: begin
                legal_s = 1'b1; raw_s.inst_type = INST_BRANCH;
                raw_s.rena1 = 1'b1; raw_s.rena2 = 1'b1; imm_raw_s = imm_b_s;
                case (funct3_s)
                    3'b000:  raw_s.bpu_op = BPU_OP_BEQ;
                    3'b001:  raw_s.bpu_op = BPU_OP_BNE;
                    3'b100:  raw_s.bpu_op = BPU_OP_BLT;
                    3'b101:  raw_s.bpu_op = BPU_OP_BGE;
                    3'b110:  raw_s.bpu_op = BPU_OP_BLTU;
                    3'b111:  raw_s.bpu_op = BPU_OP_BGEU;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal_s = 1'b1; raw_s.inst_type = INST_LOAD; raw_s.alu_op = ALU_OP_ADD;
                raw_s.wsel = 1'b1; raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; imm_raw_s = imm_i_s;
                case (funct3_s)
                    3'b000:  raw_s.lsu_op = LSU_OP_LB;
                    3'b001:  raw_s.lsu_op = LSU_OP_LH;
                    3'b010:  raw_s.lsu_op = LSU_OP_LW;
                    3'b100:  raw_s.lsu_op = LSU_OP_LBU;
                    3'b101:  raw_s.lsu_op = LSU_OP_LHU;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                legal_s = 1'b1; raw_s.inst_type = INST_STORE; raw_s.alu_op = ALU_OP_ADD;
                raw_s.rena1 = 1'b1; raw_s.rena2 = 1'b1; imm_raw_s = imm_st_s;
                case (funct3_s)
                    3'b000:  raw_s.lsu_op = LSU_OP_SB;
                    3'b001:  raw_s.lsu_op = LSU_OP_SH;
                    3'b010:  raw_s.lsu_op = LSU_OP_SW;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                legal_s = 1'b1; raw_s.inst_type = INST_ALU;
                raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; imm_raw_s = imm_i_s;
                case (funct3_s)
                    3'b000:  raw_s.alu_op = ALU_OP_ADD;
                    3'b010:  raw_s.alu_op = ALU_OP_SLT;
                    3'b011:  raw_s.alu_op = ALU_OP_SLTU;
                    3'b100:  raw_s.alu_op = ALU_OP_XOR;
                    3'b110:  raw_s.alu_op = ALU_OP_OR;
                    3'b111:  raw_s.alu_op = ALU_OP_AND;
                    3'b001: begin
                        legal_s = sll_ok_s; raw_s.alu_op = ALU_OP_SLL; imm_raw_s = shamt_s;
                    end
                    3'b101: begin
                        legal_s = sr_ok_s; imm_raw_s = shamt_s;
                        raw_s.alu_op = inst_i[30] ? ALU_OP_SRA : ALU_OP_SRL;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                raw_s.inst_type = INST_ALU; raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; raw_s.rena2 = 1'b1;
                if (funct7_s == F7_BASE) begin
                    legal_s = 1'b1;
                    case (funct3_s)
                        3'b000:  raw_s.alu_op = ALU_OP_ADD;
                        3'b001:  raw_s.alu_op = ALU_OP_SLL;
                        3'b010:  raw_s.alu_op = ALU_OP_SLT;
                        3'b011:  raw_s.alu_op = ALU_OP_SLTU;
                        3'b100:  raw_s.alu_op = ALU_OP_XOR;
                        3'b101:  raw_s.alu_op = ALU_OP_SRL;
                        3'b110:  raw_s.alu_op = ALU_OP_OR;
                        3'b111:  raw_s.alu_op = ALU_OP_AND;
                        default: legal_s = 1'b0;
                    endcase
                end else if (funct7_s == F7_ALT) begin
                    case (funct3_s)
                        3'b000:  begin legal_s = 1'b1; raw_s.alu_op = ALU_OP_SUB; end
                        3'b101:  begin legal_s = 1'b1; raw_s.alu_op = ALU_OP_SRA; end
                        default: legal_s = 1'b0;
                    endcase
                end else if ((funct7_s == F7_MULDIV) && (M_EXT != 0)) begin
                    legal_s = 1'b1; raw_s.inst_type = INST_MDU;
                    case (funct3_s)
                        3'b000:  raw_s.mdu_op = MDU_OP_MUL;
                        3'b001:  raw_s.mdu_op = MDU_OP_MULH;
                        3'b010:  raw_s.mdu_op = MDU_OP_MULHSU;
                        3'b011:  raw_s.mdu_op = MDU_OP_MULHU;
                        3'b100:  raw_s.mdu_op = MDU_OP_DIV;
                        3'b101:  raw_s.mdu_op = MDU_OP_DIVU;
                        3'b110:  raw_s.mdu_op = MDU_OP_REM;
                        3'b111:  raw_s.mdu_op = MDU_OP_REMU;
                        default: legal_s = 1'b0;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_SYSTEM: begin
                case (funct3_s)
                    3'b000: begin
                        raw_s.inst_type = INST_SYS;
                        if (inst_i == SYS_ECALL) begin
                            legal_s = 1'b1; raw_s.csr_op = CSR_OP_ECALL;
                        end else if (inst_i == SYS_EBREAK) begin
                            legal_s = 1'b1; raw_s.ebreak = 1'b1;
                        end else if (inst_i == SYS_MRET) begin
                            legal_s = 1'b1; raw_s.csr_op = CSR_OP_MRET;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    3'b001: begin
                        legal_s = 1'b1; raw_s.inst_type = INST_CSR; raw_s.csr_op = CSR_OP_RW;
                        raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; imm_raw_s = csr_addr_s;
                    end
                    3'b010: begin
                        legal_s = 1'b1; raw_s.inst_type = INST_CSR; raw_s.csr_op = CSR_OP_RS;
                        raw_s.wena = 1'b1; raw_s.rena1 = 1'b1; imm_raw_s = csr_addr_s;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Apply legality and zero the address of every disabled register port.
    always_comb begin
        ctrl_o = DEC_CTRL_NOP;
        imm_o  = '0;
        if (legal_s) begin
            ctrl_o        = raw_s;
            ctrl_o.waddr  = raw_s.wena  ? raw_s.waddr  : 5'd0;
            ctrl_o.raddr1 = raw_s.rena1 ? raw_s.raddr1 : 5'd0;
            ctrl_o.raddr2 = raw_s.rena2 ? raw_s.raddr2 : 5'd0;
            imm_o         = imm_raw_s;
        end else begin
            ctrl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: decodes the fetched word and buffers decoded bundles in a
// small FIFO between the IFU and EXU handshakes.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [XLEN-1:0]        pc_i,
    input  logic [31:0]            inst_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        pc_o,
    output logic [XLEN-1:0]        imm_o,
    output logic [INST_TYPE_W-1:0] inst_type_o,
    output logic [ALU_OP_W-1:0]    alu_op_o,
    output logic [LSU_OP_W-1:0]    lsu_op_o,
    output logic [BPU_OP_W-1:0]    bpu_op_o,
    output logic [CSR_OP_W-1:0]    csr_op_o,
    output logic [MDU_OP_W-1:0]    mdu_op_o,
    output logic                   wsel_o,
    output logic                   wena_o,
    output logic                   rena1_o,
    output logic                   rena2_o,
    output logic [4:0]             waddr_o,
    output logic [4:0]             raddr1_o,
    output logic [4:0]             raddr2_o,
    output logic                   illegal_o,
    output logic                   ebreak_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    dec_ctrl_t       dec_ctrl_s;
    logic [XLEN-1:0] dec_imm_s;

    dec_ctrl_t       ctrl_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] imm_mem_q  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_s, pop_s;

    dec_ctrl_t        head_ctrl_s;
    logic [XLEN-1:0]  head_pc_s;
    logic [XLEN-1:0]  head_imm_s;

    idu_dec #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_dec (
        .inst_i (inst_i),
        .ctrl_o (dec_ctrl_s),
        .imm_o  (dec_imm_s)
    );

    assign in_ready_o  = (count_q < DEPTH_C);
    assign out_valid_o = (count_q != {CNT_W{1'b0}});
    assign push_s      = in_valid_i && in_ready_o && !flush_i;
    assign pop_s       = out_valid_o && out_ready_i;

    // Next-state for pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is left unreset; the head is masked whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (push_s) begin
            ctrl_mem_q[wr_ptr_q] <= dec_ctrl_s;
            pc_mem_q[wr_ptr_q]   <= pc_i;
            imm_mem_q[wr_ptr_q]  <= dec_imm_s;
        end
    end

    // Head entry selection with empty-queue masking.
    always_comb begin
        head_ctrl_s = DEC_CTRL_NOP;
        head_pc_s   = '0;
        head_imm_s  = '0;
        if (out_valid_o) begin
            head_ctrl_s = ctrl_mem_q[rd_ptr_q];
            head_pc_s   = pc_mem_q[rd_ptr_q];
            head_imm_s  = imm_mem_q[rd_ptr_q];
        end else begin
            head_ctrl_s = DEC_CTRL_NOP;
            head_pc_s   = '0;
            head_imm_s  = '0;
        end
    end

    assign pc_o        = head_pc_s;
    assign imm_o       = head_imm_s;
    assign inst_type_o = head_ctrl_s.inst_type;
    assign alu_op_o    = head_ctrl_s.alu_op;
    assign lsu_op_o    = head_ctrl_s.lsu_op;
    assign bpu_op_o    = head_ctrl_s.bpu_op;
    assign csr_op_o    = head_ctrl_s.csr_op;
    assign mdu_op_o    = head_ctrl_s.mdu_op;
    assign wsel_o      = head_ctrl_s.wsel;
    assign wena_o      = head_ctrl_s.wena;
    assign rena1_o     = head_ctrl_s.rena1;
    assign rena2_o     = head_ctrl_s.rena2;
    assign waddr_o     = head_ctrl_s.waddr;
    assign raddr1_o    = head_ctrl_s.raddr1;
    assign raddr2_o    = head_ctrl_s.raddr2;
    assign illegal_o   = head_ctrl_s.illegal;
    assign ebreak_o    = head_ctrl_s.ebreak;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: three instances (default, M_EXT=0, XLEN=64)
// share one stimulus stream; each task checks its own scenario.
module tb_idu_pipe;
    import idu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [31:0] pc32 = 32'd0;
    logic [63:0] pc64;
    int          checks = 0;
    int          errors = 0;

    assign pc64 = {32'd0, pc32};

    logic a_in_ready, a_out_valid, a_wsel, a_wena, a_rena1, a_rena2, a_illegal, a_ebreak;
    logic [31:0] a_pc, a_imm;
    logic [3:0] a_type, a_alu, a_lsu, a_bpu, a_mdu;
    logic [2:0] a_csr;
    logic [4:0] a_waddr, a_raddr1, a_raddr2;

    logic m_in_ready, m_out_valid, m_wsel, m_wena, m_rena1, m_rena2, m_illegal, m_ebreak;
    logic [31:0] m_pc, m_imm;
    logic [3:0] m_type, m_alu, m_lsu, m_bpu, m_mdu;
    logic [2:0] m_csr;
    logic [4:0] m_waddr, m_raddr1, m_raddr2;

    logic x_in_ready, x_out_valid, x_wsel, x_wena, x_rena1, x_rena2, x_illegal, x_ebreak;
    logic [63:0] x_pc, x_imm;
    logic [3:0] x_type, x_alu, x_lsu, x_bpu, x_mdu;
    logic [2:0] x_csr;
    logic [4:0] x_waddr, x_raddr1, x_raddr2;

    idu_pipe #(.XLEN(32), .M_EXT(1), .DEPTH(2)) u_a (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .pc_i(pc32), .inst_i(inst), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .pc_o(a_pc), .imm_o(a_imm), .inst_type_o(a_type), .alu_op_o(a_alu), .lsu_op_o(a_lsu),
        .bpu_op_o(a_bpu), .csr_op_o(a_csr), .mdu_op_o(a_mdu), .wsel_o(a_wsel), .wena_o(a_wena),
        .rena1_o(a_rena1), .rena2_o(a_rena2), .waddr_o(a_waddr), .raddr1_o(a_raddr1),
        .raddr2_o(a_raddr2), .illegal_o(a_illegal), .ebreak_o(a_ebreak));

    idu_pipe #(.XLEN(32), .M_EXT(0), .DEPTH(2)) u_m0 (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(m_in_ready),
        .pc_i(pc32), .inst_i(inst), .out_valid_o(m_out_valid), .out_ready_i(out_ready),
        .pc_o(m_pc), .imm_o(m_imm), .inst_type_o(m_type), .alu_op_o(m_alu), .lsu_op_o(m_lsu),
        .bpu_op_o(m_bpu), .csr_op_o(m_csr), .mdu_op_o(m_mdu), .wsel_o(m_wsel), .wena_o(m_wena),
        .rena1_o(m_rena1), .rena2_o(m_rena2), .waddr_o(m_waddr), .raddr1_o(m_raddr1),
        .raddr2_o(m_raddr2), .illegal_o(m_illegal), .ebreak_o(m_ebreak));

    idu_pipe #(.XLEN(64), .M_EXT(1), .DEPTH(2)) u_x64 (
        .clock(clock), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(x_in_ready),
        .pc_i(pc64), .inst_i(inst), .out_valid_o(x_out_valid), .out_ready_i(out_ready),
        .pc_o(x_pc), .imm_o(x_imm), .inst_type_o(x_type), .alu_op_o(x_alu), .lsu_op_o(x_lsu),
        .bpu_op_o(x_bpu), .csr_op_o(x_csr), .mdu_op_o(x_mdu), .wsel_o(x_wsel), .wena_o(x_wena),
        .rena1_o(x_rena1), .rena2_o(x_rena2), .waddr_o(x_waddr), .raddr1_o(x_raddr1),
        .raddr2_o(x_raddr2), .illegal_o(x_illegal), .ebreak_o(x_ebreak));

    initial forever #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_during got %b want 0", a_out_valid); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
        checks++; if (u_a.count_q !== 2'd0) begin errors++; $display("FAIL rst_count got %0d want 0", u_a.count_q); end
        checks++; if ({a_pc, a_imm} !== 64'd0) begin errors++; $display("FAIL rst_empty_bundle got %h want 0", {a_pc, a_imm}); end
        checks++; if (a_illegal !== 1'b0) begin errors++; $display("FAIL rst_empty_illegal got %b want 0", a_illegal); end
    endtask

    task automatic test_addi();
        pc32 = 32'h100; inst = 32'h0050_0093; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL addi_no_passthru got %b want 0", a_out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", a_out_valid); end
        checks++; if (a_alu !== ALU_OP_ADD) begin errors++; $display("FAIL addi_alu got %0d want %0d", a_alu, ALU_OP_ADD); end
        checks++; if (a_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %h want 5", a_imm); end
        checks++; if ({a_wena, a_waddr} !== {1'b1, 5'd1}) begin errors++; $display("FAIL addi_wr got %b/%0d want 1/1", a_wena, a_waddr); end
        checks++; if ({a_rena1, a_raddr1, a_rena2} !== {1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL addi_rd got %b/%0d/%b want 1/0/0", a_rena1, a_raddr1, a_rena2); end
        checks++; if (a_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", a_pc); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained got %b want 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1;
        pc32 = 32'h200; inst = 32'h0010_0093;
        step();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", a_in_ready); end
        pc32 = 32'h204; inst = 32'h0020_0113;
        step();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", a_in_ready); end
        pc32 = 32'h208; inst = 32'h0030_0193;
        step();
        checks++; if ({a_in_ready, a_out_valid} !== 2'b01) begin errors++; $display("FAIL b2b_held got %b want 01", {a_in_ready, a_out_valid}); end
        checks++; if ({a_pc, a_imm} !== {32'h200, 32'd1}) begin errors++; $display("FAIL b2b_stable got %h want 0000020000000001", {a_pc, a_imm}); end
        out_ready = 1'b1;
        step();
        checks++; if ({a_pc, a_imm, 27'd0, a_waddr} !== {32'h204, 32'd2, 32'd2}) begin errors++; $display("FAIL b2b_second got %h/%h/%0d want 204/2/2", a_pc, a_imm, a_waddr); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got %b want 1", a_in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({a_pc, a_imm, 27'd0, a_waddr} !== {32'h208, 32'd3, 32'd3}) begin errors++; $display("FAIL b2b_third got %h/%h/%0d want 208/3/3", a_pc, a_imm, a_waddr); end
        checks++; if (u_a.count_q !== 2'd1) begin errors++; $display("FAIL b2b_push_pop_count got %0d want 1", u_a.count_q); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        pc32 = 32'h400; inst = 32'h0010_0093; step();
        pc32 = 32'h404; inst = 32'h0020_0113; step();
        flush = 1'b1; pc32 = 32'h408; inst = 32'h0030_0193; step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b want 0", a_out_valid); end
        checks++; if (u_a.count_q !== 2'd0) begin errors++; $display("FAIL flush_full_count got %0d want 0", u_a.count_q); end
        out_ready = 1'b1; step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_delivery got %b want 0", a_out_valid); end
        out_ready = 1'b0; in_valid = 1'b1; pc32 = 32'h410; inst = 32'h0040_0213; step();
        flush = 1'b1; pc32 = 32'h414; inst = 32'h0030_0193; step();
        flush = 1'b0;
        checks++; if ({a_out_valid, u_a.count_q, u_a.wr_ptr_q} !== 4'b0000) begin errors++; $display("FAIL flush_part got %b want 0000", {a_out_valid, u_a.count_q, u_a.wr_ptr_q}); end
        pc32 = 32'h500; inst = 32'h0050_0293; step();
        in_valid = 1'b0;
        checks++; if ({a_pc, a_imm, 27'd0, a_waddr} !== {32'h500, 32'd5, 32'd5}) begin errors++; $display("FAIL flush_restart got %h/%h/%0d want 500/5/5", a_pc, a_imm, a_waddr); end
        out_ready = 1'b1; step();
    endtask

    task automatic test_decode();
        out_ready = 1'b1; in_valid = 1'b1;
        inst = 32'h0020_A423; step();
        checks++; if ({a_lsu, a_imm} !== {LSU_OP_SW, 32'd8}) begin errors++; $display("FAIL sw_op_imm got %0d/%h want %0d/8", a_lsu, a_imm, LSU_OP_SW); end
        checks++; if ({a_wena, a_waddr, a_rena1, a_raddr1, a_rena2, a_raddr2} !== {1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd2}) begin errors++; $display("FAIL sw_regs got %b %0d %b %0d %b %0d want 0 0 1 1 1 2", a_wena, a_waddr, a_rena1, a_raddr1, a_rena2, a_raddr2); end
        inst = 32'hFE00_0EE3; step();
        checks++; if ({a_bpu, a_imm, a_waddr} !== {BPU_OP_BEQ, 32'hFFFF_FFFC, 5'd0}) begin errors++; $display("FAIL beq got %0d/%h/%0d want %0d/fffffffc/0", a_bpu, a_imm, a_waddr, BPU_OP_BEQ); end
        inst = 32'hFFFF_FFFF; step();
        checks++; if ({a_illegal, a_imm, a_wena, a_rena1, a_rena2, a_waddr, a_alu, a_type} !== {1'b1, 32'd0, 3'b000, 5'd0, ALU_OP_NOP, INST_NOP}) begin errors++; $display("FAIL illegal_word got %b/%h/%b%b%b/%0d want 1/0/000/0", a_illegal, a_imm, a_wena, a_rena1, a_rena2, a_waddr); end
        inst = 32'h0010_0073; step();
        checks++; if ({a_ebreak, a_illegal, a_wena, a_type} !== {3'b100, INST_SYS}) begin errors++; $display("FAIL ebreak got %b%b%b/%0d want 100/%0d", a_ebreak, a_illegal, a_wena, a_type, INST_SYS); end
        in_valid = 1'b0; step();
    endtask

    task automatic test_mext();
        out_ready = 1'b1; in_valid = 1'b1; inst = 32'h0220_8033; step();
        in_valid = 1'b0;
        checks++; if ({m_illegal, m_wena, m_mdu} !== {2'b10, MDU_OP_NOP}) begin errors++; $display("FAIL mul_m0 got %b%b/%0d want 10/0", m_illegal, m_wena, m_mdu); end
        checks++; if ({a_illegal, a_mdu, a_type} !== {1'b0, MDU_OP_MUL, INST_MDU}) begin errors++; $display("FAIL mul_m1 got %b/%0d/%0d want 0/%0d/%0d", a_illegal, a_mdu, a_type, MDU_OP_MUL, INST_MDU); end
        step();
    endtask

    task automatic test_rv64();
        out_ready = 1'b1; in_valid = 1'b1;
        inst = 32'h0210_9093; step();
        checks++; if ({x_illegal, x_alu, x_imm[5:0]} !== {1'b0, ALU_OP_SLL, 6'd33}) begin errors++; $display("FAIL slli64 got %b/%0d/%0d want 0/%0d/33", x_illegal, x_alu, x_imm[5:0], ALU_OP_SLL); end
        checks++; if (a_illegal !== 1'b1) begin errors++; $display("FAIL slli33_rv32 got %b want 1", a_illegal); end
        inst = 32'h8000_00B7; step();
        checks++; if (x_imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui64_imm got %h want ffffffff80000000", x_imm); end
        checks++; if ({a_imm, a_waddr} !== {32'h8000_0000, 5'd1}) begin errors++; $display("FAIL lui32 got %h/%0d want 80000000/1", a_imm, a_waddr); end
        inst = 32'h4280_D093; step();
        checks++; if ({x_illegal, x_alu, x_imm} !== {1'b0, ALU_OP_SRA, 64'd40}) begin errors++; $display("FAIL srai64 got %b/%0d/%0d want 0/%0d/40", x_illegal, x_alu, x_imm, ALU_OP_SRA); end
        inst = 32'h0010_009B; step();
        in_valid = 1'b0;
        checks++; if ({x_illegal, x_wena} !== 2'b10) begin errors++; $display("FAIL addiw64 got %b%b want 10", x_illegal, x_wena); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; pc32 = 32'h600; inst = 32'h0010_0093; step();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", a_out_valid); end
        #2; reset = 1'b1; #1;
        checks++; if ({a_out_valid, u_a.count_q} !== 3'b000) begin errors++; $display("FAIL midrst_async got %b want 000", {a_out_valid, u_a.count_q}); end
        step();
        reset = 1'b0; #1;
        checks++; if ({a_in_ready, a_out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_release got %b want 10", {a_in_ready, a_out_valid}); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_flush();
        test_decode();
        test_mext();
        test_rv64();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
